// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the 5-stage RISC-V core.
// Holds default widths, control-field encodings and the ID/EX control word layout.
package riscv_pipe_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_RA_W  = 5;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2,
        RES_IMM = 2'd3
    } res_src_e;

    typedef enum logic [1:0] {
        JMP_NONE = 2'd0,
        JMP_JAL  = 2'd1,
        JMP_JALR = 2'd2
    } jump_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_BLTU = 3'd5,
        BR_BGEU = 3'd6
    } branch_e;

    // An all-zero word is a bubble: no write, no jump, no branch, not valid.
    typedef struct packed {
        logic       valid;
        logic       alu_src;
        logic       mem_write;
        logic       reg_write;
        logic       lui;
        res_src_e   result_src;
        jump_e      jump;
        logic [2:0] alu_ctrl;
        branch_e    branch;
    } ctrl_t;

    localparam ctrl_t CTRL_ZERO = '0;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX boundary bundle: decode-side inputs, hazard controls and EX-side outputs.
// Handshake: the D side presents a slot every cycle with validD; the register takes it
// on an edge unless stallE holds EX, and flushE overrides both by loading a bubble.
interface id_ex_pipe_reg_if
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int RA_W  = DEF_RA_W,
    parameter int CNT_W = DEF_CNT_W
);
    logic            stallE, flushE;
    logic            validD, AluSrcD, memWriteD, regWriteD, luiD;
    logic [1:0]      resultSrcD, JumpD;
    logic [2:0]      AluControlD, BranchD;
    logic [XLEN-1:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
    logic [RA_W-1:0] Rs1D, Rs2D, RdD;

    logic            validE, AluSrcE, memWriteE, regWriteE, luiE;
    logic [1:0]      resultSrcE, JumpE;
    logic [2:0]      AluControlE, BranchE;
    logic [XLEN-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [RA_W-1:0] Rs1E, Rs2E, RdE;
    logic [CNT_W-1:0] bubbleCnt;

    modport master (
        output stallE, flushE, validD, AluSrcD, memWriteD, regWriteD, luiD,
               resultSrcD, JumpD, AluControlD, BranchD,
               RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
        input  validE, AluSrcE, memWriteE, regWriteE, luiE,
               resultSrcE, JumpE, AluControlE, BranchE,
               RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, bubbleCnt
    );

    modport slave (
        input  stallE, flushE, validD, AluSrcD, memWriteD, regWriteD, luiD,
               resultSrcD, JumpD, AluControlD, BranchD,
               RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
        output validE, AluSrcE, memWriteE, regWriteE, luiE,
               resultSrcE, JumpE, AluControlE, BranchE,
               RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, bubbleCnt
    );

endinterface

// File: rtl/pipe_reg_sfc.sv
// Generic pipeline flop with async clear, stall (hold) and flush (clear).
// Flush wins over stall so a squashed slot never lingers in a stalled stage.
module pipe_reg_sfc #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: turns invalid slots into bubbles, drops writes to x0,
// and counts inserted bubbles with a saturating debug counter.
module id_ex_pipe_reg
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int RA_W  = DEF_RA_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic            clk,
    input logic            rst,
    id_ex_pipe_reg_if.slave bus
);

    localparam int DW = 5 * XLEN + 3 * RA_W;

    ctrl_t            ctrl_d, ctrl_q;
    logic [DW-1:0]    data_d, data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bubble;

    always_comb begin
        ctrl_d = CTRL_ZERO;
        if (bus.validD) begin
            ctrl_d.valid      = 1'b1;
            ctrl_d.alu_src    = bus.AluSrcD;
            ctrl_d.mem_write  = bus.memWriteD;
            // A write to x0 must never look like a write to the forwarding logic.
            ctrl_d.reg_write  = bus.regWriteD & (bus.RdD != '0);
            ctrl_d.lui        = bus.luiD;
            ctrl_d.result_src = res_src_e'(bus.resultSrcD);
            ctrl_d.jump       = jump_e'(bus.JumpD);
            ctrl_d.alu_ctrl   = bus.AluControlD;
            ctrl_d.branch     = branch_e'(bus.BranchD);
        end
    end

    assign data_d = {bus.RD1D, bus.RD2D, bus.PCD, bus.PCPlus4D, bus.ImmExtD,
                     bus.Rs1D, bus.Rs2D, bus.RdD};

    pipe_reg_sfc #(.W($bits(ctrl_t))) u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .stall (bus.stallE),
        .flush (bus.flushE),
        .d     (ctrl_d),
        .q     (ctrl_q)
    );

    pipe_reg_sfc #(.W(DW)) u_data (
        .clk   (clk),
        .rst   (rst),
        .stall (bus.stallE),
        .flush (bus.flushE),
        .d     (data_d),
        .q     (data_q)
    );

    // A bubble enters EX on a flush, or on a non-stalled capture of an empty slot.
    assign bubble = bus.flushE | (~bus.stallE & ~bus.validD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (bubble && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.validE      = ctrl_q.valid;
    assign bus.AluSrcE     = ctrl_q.alu_src;
    assign bus.memWriteE   = ctrl_q.mem_write;
    assign bus.regWriteE   = ctrl_q.reg_write;
    assign bus.luiE        = ctrl_q.lui;
    assign bus.resultSrcE  = ctrl_q.result_src;
    assign bus.JumpE       = ctrl_q.jump;
    assign bus.AluControlE = ctrl_q.alu_ctrl;
    assign bus.BranchE     = ctrl_q.branch;
    assign {bus.RD1E, bus.RD2E, bus.PCE, bus.PCPlus4E, bus.ImmExtE,
            bus.Rs1E, bus.Rs2E, bus.RdE} = data_q;
    assign bus.bubbleCnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg with a 4-bit bubble counter so saturation is reachable.
module tb_id_ex_pipe_reg;

    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    id_ex_pipe_reg_if #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) bus ();

    id_ex_pipe_reg #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic            m_valid, m_alusrc, m_memw, m_regw, m_lui;
    logic [1:0]      m_res, m_jump;
    logic [2:0]      m_aluc, m_br;
    logic [XLEN-1:0] m_rd1, m_rd2, m_pc, m_pc4, m_imm;
    logic [RA_W-1:0] m_rs1, m_rs2, m_rd;
    int              m_cnt;

    task automatic m_zero_ctrl();
        m_valid = 0; m_alusrc = 0; m_memw = 0; m_regw = 0; m_lui = 0;
        m_res = 0; m_jump = 0; m_aluc = 0; m_br = 0;
    endtask

    task automatic m_zero_data();
        m_rd1 = 0; m_rd2 = 0; m_pc = 0; m_pc4 = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    endtask

    task automatic m_bump();
        if (m_cnt < CMAX) m_cnt = m_cnt + 1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_zero_ctrl();
            m_zero_data();
            m_cnt = 0;
        end else if (bus.flushE) begin
            m_zero_ctrl();
            m_zero_data();
            m_bump();
        end else if (!bus.stallE) begin
            m_rd1 = bus.RD1D; m_rd2 = bus.RD2D; m_pc = bus.PCD;
            m_pc4 = bus.PCPlus4D; m_imm = bus.ImmExtD;
            m_rs1 = bus.Rs1D; m_rs2 = bus.Rs2D; m_rd = bus.RdD;
            if (bus.validD) begin
                m_valid = 1; m_alusrc = bus.AluSrcD; m_memw = bus.memWriteD;
                m_regw = bus.regWriteD && (bus.RdD != 0);
                m_lui = bus.luiD; m_res = bus.resultSrcD; m_jump = bus.JumpD;
                m_aluc = bus.AluControlD; m_br = bus.BranchD;
            end else begin
                m_zero_ctrl();
                m_bump();
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("validE",      64'(bus.validE),      64'(m_valid));
        chk("AluSrcE",     64'(bus.AluSrcE),     64'(m_alusrc));
        chk("memWriteE",   64'(bus.memWriteE),   64'(m_memw));
        chk("regWriteE",   64'(bus.regWriteE),   64'(m_regw));
        chk("luiE",        64'(bus.luiE),        64'(m_lui));
        chk("resultSrcE",  64'(bus.resultSrcE),  64'(m_res));
        chk("JumpE",       64'(bus.JumpE),       64'(m_jump));
        chk("AluControlE", 64'(bus.AluControlE), 64'(m_aluc));
        chk("BranchE",     64'(bus.BranchE),     64'(m_br));
        chk("RD1E",        64'(bus.RD1E),        64'(m_rd1));
        chk("RD2E",        64'(bus.RD2E),        64'(m_rd2));
        chk("PCE",         64'(bus.PCE),         64'(m_pc));
        chk("PCPlus4E",    64'(bus.PCPlus4E),    64'(m_pc4));
        chk("ImmExtE",     64'(bus.ImmExtE),     64'(m_imm));
        chk("Rs1E",        64'(bus.Rs1E),        64'(m_rs1));
        chk("Rs2E",        64'(bus.Rs2E),        64'(m_rs2));
        chk("RdE",         64'(bus.RdE),         64'(m_rd));
        chk("bubbleCnt",   64'(bus.bubbleCnt),   64'(m_cnt));
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.stallE = 0; bus.flushE = 0; bus.validD = 0;
        bus.AluSrcD = 0; bus.memWriteD = 0; bus.regWriteD = 0; bus.luiD = 0;
        bus.resultSrcD = 0; bus.JumpD = 0; bus.AluControlD = 0; bus.BranchD = 0;
        bus.RD1D = 0; bus.RD2D = 0; bus.PCD = 0; bus.PCPlus4D = 0; bus.ImmExtD = 0;
        bus.Rs1D = 0; bus.Rs2D = 0; bus.RdD = 0;
    endtask

    task automatic set_random();
        bus.flushE      = ($urandom_range(0, 7) == 0);
        bus.stallE      = ($urandom_range(0, 3) == 0);
        bus.validD      = ($urandom_range(0, 3) != 0);
        bus.AluSrcD     = 1'($urandom_range(0, 1));
        bus.memWriteD   = 1'($urandom_range(0, 1));
        bus.regWriteD   = 1'($urandom_range(0, 1));
        bus.luiD        = 1'($urandom_range(0, 1));
        bus.resultSrcD  = 2'($urandom_range(0, 3));
        bus.JumpD       = 2'($urandom_range(0, 2));
        bus.AluControlD = 3'($urandom_range(0, 7));
        bus.BranchD     = 3'($urandom_range(0, 6));
        bus.RD1D        = $urandom();
        bus.RD2D        = $urandom();
        bus.PCD         = $urandom() & 32'hFFFF_FFFC;
        bus.PCPlus4D    = bus.PCD + 32'd4;
        bus.ImmExtD     = $urandom();
        bus.Rs1D        = 5'($urandom_range(0, 31));
        bus.Rs2D        = 5'($urandom_range(0, 31));
        bus.RdD         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        set_idle();
        tick();
        tick();
        chk("rst_validE", 64'(bus.validE), 64'd0);
        chk("rst_bubbleCnt", 64'(bus.bubbleCnt), 64'd0);
        chk("rst_PCE", 64'(bus.PCE), 64'd0);

        // reset then capture
        rst = 0;
        bus.validD = 1; bus.regWriteD = 1; bus.RdD = 5; bus.RD1D = 32'h1234;
        bus.AluControlD = 3'b010;
        tick();
        chk("cap_regWriteE", 64'(bus.regWriteE), 64'd1);
        chk("cap_RdE", 64'(bus.RdE), 64'd5);
        chk("cap_RD1E", 64'(bus.RD1E), 64'h1234);
        chk("cap_AluControlE", 64'(bus.AluControlE), 64'd2);
        chk("cap_validE", 64'(bus.validE), 64'd1);
        chk("cap_bubbleCnt", 64'(bus.bubbleCnt), 64'd0);

        // x0 suppression
        bus.RdD = 0;
        tick();
        chk("x0_regWriteE", 64'(bus.regWriteE), 64'd0);
        chk("x0_validE", 64'(bus.validE), 64'd1);
        chk("x0_bubbleCnt", 64'(bus.bubbleCnt), 64'd0);

        // stall hold
        bus.RdD = 1; bus.PCD = 32'h40;
        tick();
        chk("stall_load_PCE", 64'(bus.PCE), 64'h40);
        bus.stallE = 1; bus.PCD = 32'h44;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_PCE", 64'(bus.PCE), 64'h40);
        end
        bus.stallE = 0;
        tick();
        chk("stall_release_PCE", 64'(bus.PCE), 64'h44);

        // flush over stall
        bus.memWriteD = 1;
        tick();
        chk("fl_memWriteE_set", 64'(bus.memWriteE), 64'd1);
        bus.stallE = 1;
        tick();
        chk("fl_memWriteE_held", 64'(bus.memWriteE), 64'd1);
        bus.flushE = 1;
        tick();
        chk("fl_memWriteE", 64'(bus.memWriteE), 64'd0);
        chk("fl_validE", 64'(bus.validE), 64'd0);
        chk("fl_PCE", 64'(bus.PCE), 64'd0);
        chk("fl_RD1E", 64'(bus.RD1E), 64'd0);
        chk("fl_RdE", 64'(bus.RdE), 64'd0);
        chk("fl_bubbleCnt", 64'(bus.bubbleCnt), 64'd1);

        // invalid capture and saturation
        bus.flushE = 0; bus.stallE = 0; bus.validD = 0; bus.memWriteD = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("sat_memWriteE", 64'(bus.memWriteE), 64'd0);
            chk("sat_bubbleCnt", 64'(bus.bubbleCnt), 64'((i + 2 > CMAX) ? CMAX : i + 2));
        end

        // async reset mid-operation
        set_idle();
        bus.validD = 1; bus.regWriteD = 1; bus.RdD = 7; bus.PCD = 32'h80;
        tick();
        chk("pre_rst_regWriteE", 64'(bus.regWriteE), 64'd1);
        #2;
        rst = 1;
        #1;
        chk("async_validE", 64'(bus.validE), 64'd0);
        chk("async_regWriteE", 64'(bus.regWriteE), 64'd0);
        chk("async_PCE", 64'(bus.PCE), 64'd0);
        chk("async_RdE", 64'(bus.RdE), 64'd0);
        chk("async_bubbleCnt", 64'(bus.bubbleCnt), 64'd0);
        tick();
        rst = 0;
        tick();
        chk("post_rst_validE", 64'(bus.validE), 64'd1);
        chk("post_rst_RdE", 64'(bus.RdE), 64'd7);
        chk("post_rst_PCE", 64'(bus.PCE), 64'h80);
        chk("post_rst_bubbleCnt", 64'(bus.bubbleCnt), 64'd0);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            set_random();
            tick();
        end

        set_idle();
        tick();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
